// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory blocks: default data-RAM depth and the
// access-sequencing state encoding.
package cpu_mem_pkg;

  localparam int CPU_MEM_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/cpu_data_ram_bank.sv
// Four byte-wide synchronous RAM banks with per-lane write enable and a
// registered, lane-masked read port.
module cpu_data_ram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[l]) begin
        mem[addr_i] <= wdata_i[8*l +: 8];
      end
    end

    // Disabled lanes read back as zero; the register holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= be_i[l] ? mem[addr_i] : 8'h00;
      end
    end

    assign rdata_o[8*l +: 8] = rdata_q;
  end

endmodule

// File: rtl/cpu_data_ram.sv
// Byte-enabled CPU data RAM with 1-cycle registered reads and error pulses.
// Define CPU_DATA_RAM_WAIT_STATE_EN to insert WAIT_CYCLES stall cycles per access.
module cpu_data_ram
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = CPU_MEM_DEPTH_WORDS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteenable,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef CPU_DATA_RAM_WAIT_STATE_EN
  localparam bit UseWait = (WAIT_CYCLES > 0);
`else
  localparam bit UseWait = 1'b0;
`endif

  logic          reqValid;
  logic          reqLegal;
  logic          issFire;
  logic          issRead;
  logic          issWrite;
  logic          issLegal;
  logic [AW-1:0] issIdx;
  logic [31:0]   issWdata;
  logic [3:0]    issBe;
  logic          bankRe;
  logic          bankWe;
  logic [3:0]    bankBe;

  if (WAIT_CYCLES < 0) begin : g_badWait
    $error("cpu_data_ram: WAIT_CYCLES must be non-negative");
  end

  assign reqValid = mem_read | mem_write;
  assign reqLegal = ({2'b00, mem_addr[31:2]} < 32'(DEPTH_WORDS)) &&
                    (mem_addr[1:0] == 2'b00) && !(mem_read && mem_write);

  if (!UseWait) begin : g_direct
    mem_state_e state_q;
    logic       rvalid_q;
    logic       err_q;
    logic       accept;

    assign accept = (state_q == IDLE) || (state_q == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        rvalid_q <= accept & mem_read;
        err_q    <= accept & reqValid & ~reqLegal;
        state_q  <= (accept && mem_read) ? RESP : IDLE;
      end
    end

    assign issFire    = accept & reqValid;
    assign issRead    = mem_read;
    assign issWrite   = mem_write;
    assign issLegal   = reqLegal;
    assign issIdx     = mem_addr[AW+1:2];
    assign issWdata   = mem_wdata;
    assign issBe      = mem_byteenable;
    assign mem_rvalid = rvalid_q;
    assign mem_err    = err_q;
    assign mem_stall  = 1'b0;
  end

`ifdef CPU_DATA_RAM_WAIT_STATE_EN
  if (UseWait) begin : g_wait
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    mem_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          stall_q;
    logic          rvalid_q;
    logic          err_q;
    logic          pRead_q;
    logic          pWrite_q;
    logic          pLegal_q;
    logic [AW-1:0] pIdx_q;
    logic [31:0]   pWdata_q;
    logic [3:0]    pBe_q;
    logic          done;

    // The latched request reaches the banks on the edge the counter hits zero.
    assign done = (state_q == WAIT) && (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        stall_q  <= 1'b0;
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        pRead_q  <= 1'b0;
        pWrite_q <= 1'b0;
        pLegal_q <= 1'b0;
        pIdx_q   <= '0;
        pWdata_q <= '0;
        pBe_q    <= '0;
      end else begin
        case (state_q)
          WAIT: begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              stall_q  <= 1'b0;
              rvalid_q <= pRead_q;
              err_q    <= ~pLegal_q;
              state_q  <= pRead_q ? RESP : IDLE;
            end
          end
          default: begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
            if (reqValid) begin
              pRead_q  <= mem_read;
              pWrite_q <= mem_write;
              pLegal_q <= reqLegal;
              pIdx_q   <= mem_addr[AW+1:2];
              pWdata_q <= mem_wdata;
              pBe_q    <= mem_byteenable;
              cnt_q    <= CW'(WAIT_CYCLES);
              stall_q  <= 1'b1;
              state_q  <= WAIT;
            end
          end
        endcase
      end
    end

    assign issFire    = done;
    assign issRead    = pRead_q;
    assign issWrite   = pWrite_q;
    assign issLegal   = pLegal_q;
    assign issIdx     = pIdx_q;
    assign issWdata   = pWdata_q;
    assign issBe      = pBe_q;
    assign mem_rvalid = rvalid_q;
    assign mem_err    = err_q;
    assign mem_stall  = stall_q;
  end
`endif

  // Illegal reads still strobe the read port so the response data becomes zero.
  assign bankRe = issFire & issRead;
  assign bankWe = issFire & issWrite & issLegal;
  assign bankBe = issLegal ? issBe : 4'h0;

  cpu_data_ram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .re_i   (bankRe),
    .we_i   (bankWe),
    .addr_i (issIdx),
    .be_i   (bankBe),
    .wdata_i(issWdata),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_cpu_data_ram.sv
// Self-checking bench for cpu_data_ram: directed literal checks, randomized traffic
// against a word-array reference model, and wait-state checks when CPU_DATA_RAM_WAIT_STATE_EN is set.
module tb_cpu_data_ram;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_stall;
  logic        mem_err;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] expRdata;
  logic        expRvalid;
  logic        expErr;

  always #5 clk = ~clk;

  cpu_data_ram #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_wdata     (mem_wdata),
    .mem_byteenable(mem_byteenable),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .mem_stall     (mem_stall),
    .mem_err       (mem_err)
  );

`ifdef CPU_DATA_RAM_WAIT_STATE_EN
  logic        rstW_n;
  logic [31:0] wAddr;
  logic        wRead;
  logic        wWrite;
  logic [31:0] wWdata;
  logic [3:0]  wBe;
  logic [31:0] rdata2, rdata3;
  logic        rvalid2, rvalid3, stall2, stall3, err2, err3;

  cpu_data_ram #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dutW2 (
    .clk(clk), .rst_n(rstW_n), .mem_addr(wAddr), .mem_read(wRead), .mem_write(wWrite),
    .mem_wdata(wWdata), .mem_byteenable(wBe), .mem_rdata(rdata2), .mem_rvalid(rvalid2),
    .mem_stall(stall2), .mem_err(err2)
  );

  cpu_data_ram #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dutW3 (
    .clk(clk), .rst_n(rstW_n), .mem_addr(wAddr), .mem_read(wRead), .mem_write(wWrite),
    .mem_wdata(wWdata), .mem_byteenable(wBe), .mem_rdata(rdata3), .mem_rvalid(rvalid3),
    .mem_stall(stall3), .mem_err(err3)
  );

  task automatic driveW(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    wRead  = rd;
    wWrite = wr;
    wAddr  = a;
    wWdata = d;
    wBe    = be;
    @(negedge clk);
  endtask
`endif

  function automatic logic [31:0] beMask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one request at a falling edge and returns at the next falling edge,
  // when the response to that request is visible.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be);
    mem_read       = rd;
    mem_write      = wr;
    mem_addr       = a;
    mem_wdata      = d;
    mem_byteenable = be;
    @(negedge clk);
  endtask

  // Reference model: every request is judged by the legality rules and its
  // effect on a plain word array; the response belongs to the following cycle.
  always @(posedge clk or negedge rst_n) begin
    logic [29:0] w;
    bit          legal;
    if (!rst_n) begin
      expRdata  = '0;
      expRvalid = 1'b0;
      expErr    = 1'b0;
    end else begin
      w     = mem_addr[31:2];
      legal = ({2'b00, w} < 32'(DEPTH)) && (mem_addr[1:0] == 2'b00) &&
              !(mem_read && mem_write);
      expRvalid = mem_read;
      expErr    = (mem_read || mem_write) && !legal;
      if (mem_read) expRdata = legal ? (refMem[int'(w)] & beMask(mem_byteenable)) : 32'h0;
      if (mem_write && legal)
        refMem[int'(w)] = (refMem[int'(w)] & ~beMask(mem_byteenable)) |
                          (mem_wdata & beMask(mem_byteenable));
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("rvalid", {31'b0, mem_rvalid}, {31'b0, expRvalid});
      checkOutput("err", {31'b0, mem_err}, {31'b0, expErr});
      checkOutput("stall", {31'b0, mem_stall}, 32'h0);
      checkOutput("rdata", mem_rdata, expRdata);
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int unsigned k;

    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_byteenable = '0;
`ifdef CPU_DATA_RAM_WAIT_STATE_EN
    rstW_n = 1'b0;
    wRead = 1'b0; wWrite = 1'b0; wAddr = '0; wWdata = '0; wBe = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", mem_rdata, 32'h0);
    checkOutput("reset_rvalid", {31'b0, mem_rvalid}, 32'h0);
    checkOutput("reset_err", {31'b0, mem_err}, 32'h0);
    checkOutput("reset_stall", {31'b0, mem_stall}, 32'h0);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    for (int w = 0; w < 16; w++) applyStimulus(1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'((DEPTH - 1) * 4), 32'hB0DA_0001, 4'hF);

    applyStimulus(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    checkOutput("full_rvalid", {31'b0, mem_rvalid}, 32'h1);
    checkOutput("full_rdata", mem_rdata, 32'h1234_5678);

    applyStimulus(1'b0, 1'b1, 32'h10, 32'hAAAA_AAAA, 4'b0100);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    checkOutput("byte_wr_rdata", mem_rdata, 32'h12AA_5678);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0011);
    checkOutput("partial_rd_rdata", mem_rdata, 32'h0000_5678);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("hold_rvalid", {31'b0, mem_rvalid}, 32'h0);
    checkOutput("hold_rdata", mem_rdata, 32'h0000_5678);

    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF);
    checkOutput("oob_rd_err", {31'b0, mem_err}, 32'h1);
    checkOutput("oob_rd_rvalid", {31'b0, mem_rvalid}, 32'h1);
    checkOutput("oob_rd_rdata", mem_rdata, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h11, 32'hDEAD_BEEF, 4'hF);
    checkOutput("misalign_wr_err", {31'b0, mem_err}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    checkOutput("both_err", {31'b0, mem_err}, 32'h1);
    checkOutput("both_rdata", mem_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    checkOutput("illegal_no_change", mem_rdata, 32'h12AA_5678);
    checkOutput("legal_rd_no_err", {31'b0, mem_err}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'hF);
    checkOutput("last_word_err", {31'b0, mem_err}, 32'h0);
    checkOutput("last_word_rdata", mem_rdata, 32'hB0DA_0001);

    applyStimulus(1'b0, 1'b1, 32'h0, 32'h1111_1111, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h2222_2222, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h3333_3333, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("b2b_rdata0", mem_rdata, 32'h1111_1111);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    checkOutput("b2b_rvalid1", {31'b0, mem_rvalid}, 32'h1);
    checkOutput("b2b_rdata1", mem_rdata, 32'h2222_2222);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
    checkOutput("b2b_rvalid2", {31'b0, mem_rvalid}, 32'h1);
    checkOutput("b2b_rdata2", mem_rdata, 32'h3333_3333);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    checkOutput("raw_rdata", mem_rdata, 32'hCAFE_F00D);

    applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    checkOutput("be0_rd_rvalid", {31'b0, mem_rvalid}, 32'h1);
    checkOutput("be0_rd_rdata", mem_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    checkOutput("be0_wr_no_change", mem_rdata, 32'hCAFE_F00D);

    for (int n = 0; n < 1500; n++) begin
      k  = $urandom_range(0, 9);
      a  = $urandom_range(0, 15) << 2;
      if ($urandom_range(0, 7) == 0) a = 32'((DEPTH - 1) * 4);
      d  = $urandom;
      be = 4'($urandom);
      case (k)
        0, 1, 2, 3: applyStimulus(1'b1, 1'b0, a, d, be);
        4, 5, 6:    applyStimulus(1'b0, 1'b1, a, d, be);
        7:          applyStimulus(1'b0, 1'b0, a, d, be);
        8: begin
          case ($urandom_range(0, 2))
            0:       a = a | 32'($urandom_range(1, 3));
            1:       a = 32'(DEPTH * 4) + ($urandom_range(0, 4000) << 2);
            default: a = 32'hFFFF_FFFC;
          endcase
          applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d, be);
        end
        default: applyStimulus(1'b1, 1'b1, a, d, be);
      endcase
    end

    mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h40; mem_byteenable = 4'hF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rvalid", {31'b0, mem_rvalid}, 32'h0);
    checkOutput("async_rst_rdata", mem_rdata, 32'h0);
    checkOutput("async_rst_err", {31'b0, mem_err}, 32'h0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("no_rvalid_after_rst", {31'b0, mem_rvalid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    checkOutput("ram_kept_over_rst", mem_rdata, 32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

`ifdef CPU_DATA_RAM_WAIT_STATE_EN
    rstW_n = 1'b1;
    driveW(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    checkOutput("w2_wr_stall", {31'b0, stall2}, 32'h1);
    repeat (5) driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    driveW(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    checkOutput("w2_stall_c1", {31'b0, stall2}, 32'h1);
    checkOutput("w2_rvalid_c1", {31'b0, rvalid2}, 32'h0);
    driveW(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    checkOutput("w2_stall_c2", {31'b0, stall2}, 32'h1);
    checkOutput("w2_rvalid_c2", {31'b0, rvalid2}, 32'h0);
    driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("w2_stall_c3", {31'b0, stall2}, 32'h0);
    checkOutput("w2_rvalid_c3", {31'b0, rvalid2}, 32'h1);
    checkOutput("w2_rdata_c3", rdata2, 32'h1122_3344);
    driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("w3_rvalid_c4", {31'b0, rvalid3}, 32'h1);
    checkOutput("w3_rdata_c4", rdata3, 32'h1122_3344);
    repeat (3) driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    driveW(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    repeat (2) driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("w2_ignored_wr", rdata2, 32'h1122_3344);
    repeat (4) driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    driveW(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
    wWrite = 1'b0;
    checkOutput("w3_pending_stall", {31'b0, stall3}, 32'h1);
    #2;
    rstW_n = 1'b0;
    #1;
    checkOutput("w3_rst_stall", {31'b0, stall3}, 32'h0);
    checkOutput("w3_rst_rvalid", {31'b0, rvalid3}, 32'h0);
    checkOutput("w3_rst_err", {31'b0, err3}, 32'h0);
    checkOutput("w3_rst_rdata", rdata3, 32'h0);
    repeat (2) @(negedge clk);
    rstW_n = 1'b1;
    driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("w3_no_rvalid_after_rst", {31'b0, rvalid3}, 32'h0);
    driveW(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    repeat (3) driveW(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("w3_aborted_rvalid", {31'b0, rvalid3}, 32'h1);
    checkOutput("w3_aborted_wr_old", rdata3, 32'h1122_3344);
`endif

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cpu_data_ram.md
CPU_DATA_RAM -- requirements
Module: cpu_data_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the stall cycles per access; it is used only when the macro in REQ-027 is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_addr, input, 32 bits: byte address of the access; bits [1:0] are expected to be 0.
REQ-006 SHALL have port mem_read, input, 1 bit: read request.
REQ-007 SHALL have port mem_write, input, 1 bit: write request.
REQ-008 SHALL have port mem_wdata, input, 32 bits: write data, with lanes already replicated by the initiator.
REQ-009 SHALL have port mem_byteenable, input, 4 bits: byte-lane enables; bit i selects bits [8i+7:8i].
REQ-010 SHALL have port mem_rdata, output, 32 bits: registered read data.
REQ-011 SHALL have port mem_rvalid, output, 1 bit: one-cycle pulse marking mem_rdata valid.
REQ-012 SHALL have port mem_stall, output, 1 bit: an access is in progress and the initiator must hold its request.
REQ-013 SHALL have port mem_err, output, 1 bit: one-cycle pulse flagging an illegal access.

Function
REQ-014 SHALL decode the word index as mem_addr[31:2]; an access is legal only when:
- the word index is below DEPTH_WORDS;
- mem_addr[1:0] == 0;
- mem_read and mem_write are not both high.
REQ-015 SHALL, on a legal write accepted at edge N, update only the enabled byte lanes at edge N; disabled lanes keep their old contents.
REQ-016 SHALL, for a legal read accepted at edge N, drive mem_rdata and mem_rvalid=1 during cycle N+1 only (1-cycle latency).
REQ-017 SHALL drive mem_rdata lanes whose byteenable bit was 0 at acceptance to 8'h00.
REQ-018 SHALL hold mem_rdata at its last value while mem_rvalid=0.
REQ-019 SHALL return the new data when a read of address A immediately follows a write to A (write at edge N, read at edge N+1).
REQ-020 SHALL treat mem_byteenable=4'b0000 as a legal no-op: a write changes nothing, and a read returns 0 with rvalid.
REQ-021 SHALL, on an illegal access, write nothing, pulse mem_err the next cycle, and, if mem_read was high, pulse mem_rvalid with mem_rdata=0.
REQ-022 SHALL use FSM states IDLE, WAIT and RESP:
- IDLE goes to RESP on a read, and stays in IDLE on a write or no request;
- RESP returns to IDLE after one cycle;
- WAIT exists only under REQ-027.
REQ-023 SHALL accept a new request in RESP (back-to-back reads give one rvalid per cycle).

Reset
REQ-024 SHALL, while rst_n=0, force the following regardless of clk: mem_rdata=0, mem_rvalid=0, mem_stall=0, mem_err=0, FSM=IDLE, wait counter=0.
REQ-025 SHALL NOT clear the RAM array on reset; its contents are undefined until written.
REQ-026 SHALL abort any pending access when reset asserts mid-access:
- a pending write is not committed;
- no rvalid is produced for it after release.

Configuration
REQ-027 SHALL, when CPU_DATA_RAM_WAIT_STATE_EN is defined:
- latch the request at acceptance and enter WAIT;
- hold mem_stall=1 for exactly WAIT_CYCLES cycles, counting down in a counter of width $clog2(WAIT_CYCLES+1);
- ignore new requests while in WAIT;
- commit a write on the edge the counter reaches 0;
- for a read, pulse mem_rvalid in the following cycle;
- with WAIT_CYCLES=0, behave exactly as without the macro.
REQ-028 SHALL, when CPU_DATA_RAM_WAIT_STATE_EN is undefined, tie mem_stall to 0 and contain no WAIT state or counter logic.

Structure
REQ-029 SHALL take the FSM state enum and the default DEPTH_WORDS constant from the shared package cpu_mem_pkg.
REQ-030 SHALL instantiate one sub-module, cpu_data_ram_bank: four byte-wide synchronous banks with per-lane write enable and registered read.

Verification
REQ-031 SHALL cover a full-word write and read:
- write 0x12345678 to 0x10 with BE=1111, then read 0x10 with BE=1111;
- required: rvalid one cycle after the read, rdata=0x12345678.
REQ-032 SHALL cover a byte write and a partial read:
- write 0xAAAAAAAA to 0x10 with BE=0100, then read 0x10 with BE=1111 -> rdata=0x12AA5678;
- read 0x10 with BE=0011 -> rdata=0x00005678.
REQ-033 SHALL cover illegal accesses, each producing an mem_err pulse:
- read at 0x1000 (word 1024) -> rdata=0 with rvalid;
- write at 0x11 -> no RAM change;
- mem_read and mem_write both high -> no RAM change.
REQ-034 SHALL cover back-to-back reads at 0x0, 0x4, 0x8 on consecutive edges:
- required: three consecutive rvalid pulses with the matching data;
- then write A followed immediately by a read of A returns the new data.
REQ-035 SHALL cover reset mid-access:
- with the macro defined and WAIT_CYCLES=3, issue a write to 0x20 and assert rst_n=0 during WAIT;
- required: all outputs 0 immediately, and a later read of 0x20 returns the old value.
REQ-036 SHALL cover wait-state timing with the macro defined and WAIT_CYCLES=2:
- required: stall high for 2 cycles, then rvalid;
- a request driven during the stall is ignored.
